// File: rtl/detector_decenas.sv
// Splits a 4-bit binary value into a registered two-digit BCD pair:
// tens flag d and units digit u, with one cycle of latency.
module detector_decenas (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in,
   output logic       d,
   output logic [3:0] u
);

   logic       d_d, d_q;
   logic [3:0] u_d, u_q;

   // 0..15 spans at most one ten, so a single conditional subtract yields mod 10.
   always_comb begin
      d_d = (in >= 4'd10);
      u_d = in;
      if (d_d) begin
         u_d = in - 4'd10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
         u_q <= 4'd0;
      end else begin
         d_q <= d_d;
         u_q <= u_d;
      end
   end

   assign d = d_q;
   assign u = u_q;

endmodule

// File: tb/tb_detector_decenas.sv
// Scoreboard bench for detector_decenas: expected {d,u} pairs are queued when
// stimulus is driven and compared one cycle later.
module tb_detector_decenas;

   logic       clk;
   logic       rst;
   logic [3:0] in;
   logic       d;
   logic [3:0] u;

   int unsigned n_checks;
   int unsigned n_pass;
   logic [4:0]  sb_q[$];

   detector_decenas dut (
      .clk(clk),
      .rst(rst),
      .in (in),
      .d  (d),
      .u  (u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] model(input logic [3:0] v, input logic r);
      logic [3:0] units;
      if (r) return 5'd0;
      if (v >= 4'd10) begin
         units = v - 4'd10;
         return {1'b1, units};
      end
      return {1'b0, v};
   endfunction

   task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got d=%0d u=%0d, want d=%0d u=%0d",
                  tag, obs[4], obs[3:0], exp[4], exp[3:0]);
      end
   endtask

   task automatic pop_and_check(input string tag);
      logic [4:0] exp;
      if (sb_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty", tag);
         $fatal(1, "scoreboard underflow");
      end
      exp = sb_q.pop_front();
      check_eq(tag, {d, u}, exp);
   endtask

   // Drive on the falling edge, sample just after the following rising edge.
   task automatic step(input logic [3:0] v, input logic r, input string tag);
      @(negedge clk);
      in  = v;
      rst = r;
      sb_q.push_back(model(v, r));
      @(posedge clk);
      #1;
      pop_and_check(tag);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      in       = 4'd15;

      step(4'd15, 1'b1, "reset0");
      step(4'd15, 1'b1, "reset1");

      for (int i = 0; i < 16; i++) begin
         step(4'(i), 1'b0, $sformatf("sweep_%0d", i));
      end

      step(4'd9,  1'b0, "bound_9");
      step(4'd10, 1'b0, "bound_10");

      // Input changes mid-cycle; outputs must keep the old sample until the edge.
      step(4'd3, 1'b0, "lat_pre");
      #2;
      in = 4'd12;
      sb_q.push_back(model(4'd12, 1'b0));
      #1;
      check_eq("lat_hold", {d, u}, model(4'd3, 1'b0));
      @(negedge clk);
      check_eq("lat_hold_neg", {d, u}, model(4'd3, 1'b0));
      @(posedge clk);
      #1;
      pop_and_check("lat_new");

      step(4'd14, 1'b1, "rst_prio");
      step(4'd14, 1'b0, "rst_release");

      step(4'd7, 1'b0, "mid_pre");
      step(4'd8, 1'b1, "mid_rst");
      step(4'd8, 1'b0, "mid_after");

      for (int k = 0; k < 5; k++) begin
         step(4'd11, 1'b0, $sformatf("hold_%0d", k));
         @(negedge clk);
         check_eq($sformatf("hold_mid_%0d", k), {d, u}, model(4'd11, 1'b0));
      end

      if (sb_q.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
         n_checks++;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
